bcd_stopwatch_core: RTL

BCD_STOPWATCH_CORE -- requirements
Module: bcd_stopwatch_core

---
 rtl/bcd_stopwatch_core.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_core.sv
// rtl/bcd_stopwatch_core.sv - mm:ss.t BCD stopwatch core; optional lap freeze under STOPWATCH_LAP_EN
module bcd_stopwatch_core #(
  parameter int FPGA_FREQ = 50_000_000,
  parameter int TICK_FREQ = 10,
  parameter int WRAP      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        up,
  input  logic        load,
  input  logic [19:0] load_val,
  input  logic        lap,
  output logic [19:0] digits,
  output logic        running,
  output logic        tick,
  output logic        done
);

  localparam int DIV = FPGA_FREQ / TICK_FREQ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  // Per-digit maximum, index 0 = tenths ... index 4 = tens of minutes
  localparam logic [4:0][3:0] DMAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9};
  localparam logic [19:0] CNT_MAX = 20'h59599;
  localparam logic [19:0] CNT_ONE = 20'h00001;

  typedef enum logic {ST_PAUSED = 1'b0, ST_RUNNING = 1'b1} state_t;

  state_t           state, state_next;
  logic [4:0][3:0]  cnt, cnt_next, cnt_inc, cnt_dec, load_clamped;
  logic [PW-1:0]    presc, presc_next;
  logic             carry, borrow;

  // Ripple increment/decrement of the BCD count with per-digit moduli
  always_comb begin
    cnt_inc = cnt;
    cnt_dec = cnt;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (carry) begin
        if (cnt[i] >= DMAX[i]) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt[i] + 4'd1;
          carry      = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt[i] == 4'd0) begin
          cnt_dec[i] = DMAX[i];
        end else begin
          cnt_dec[i] = cnt[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
  end

  // Clamp each preset field to its digit maximum
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < 5; i++) begin
      load_clamped[i] = (load_val[4*i +: 4] > DMAX[i]) ? DMAX[i] : load_val[4*i +: 4];
    end
  end

  // Run/pause state, count and prescaler registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_PAUSED;
      cnt   <= '0;
      presc <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      presc <= presc_next;
    end
  end

  // Next state and strobes; clear > load > start_stop > tick
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    presc_next = presc;
    tick       = 1'b0;
    done       = 1'b0;
    if (clear) begin
      state_next = ST_PAUSED;
      cnt_next   = '0;
      presc_next = '0;
    end else if (load) begin
      state_next = ST_PAUSED;
      cnt_next   = load_clamped;
      presc_next = '0;
    end else if (start_stop) begin
      // Prescaler is frozen on this edge so a resume continues the same phase
      if (state == ST_RUNNING) begin
        state_next = ST_PAUSED;
      end else if (up || (cnt != '0)) begin
        state_next = ST_RUNNING;
      end
    end else if (state == ST_RUNNING) begin
      if (presc == PRE_LAST) begin
        presc_next = '0;
        tick       = 1'b1;
        if (up) begin
          if (cnt == CNT_MAX) begin
            done = 1'b1;
            if (WRAP != 0) begin
              cnt_next = '0;
            end else begin
              state_next = ST_PAUSED;
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          // Reaching zero (or sitting at zero after a direction flip) ends the run
          if ((cnt == CNT_ONE) || (cnt == '0)) begin
            cnt_next   = '0;
            done       = 1'b1;
            state_next = ST_PAUSED;
          end else begin
            cnt_next = cnt_dec;
          end
        end
      end else begin
        presc_next = presc + PW'(1);
      end
    end
  end

  assign running = (state == ST_RUNNING);

`ifdef STOPWATCH_LAP_EN
  logic frozen;

  // Display register with lap freeze; clear/load release the freeze
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen <= 1'b0;
      digits <= '0;
    end else if (clear || load) begin
      frozen <= 1'b0;
      digits <= cnt;
    end else if (lap) begin
      frozen <= ~frozen;
      digits <= cnt;
    end else if (!frozen) begin
      digits <= cnt;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;

  // Display register follows the live count one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '0;
    end else begin
      digits <= cnt;
    end
  end
`endif

endmodule
